mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-stage load/store unit that initiates accesses into the byte-lane BRAM addresser, the responder that owns the four 8-bit banks. It accepts one load/store request at a time from the execute/memory pipeline register and drives the addresser's request port: address, store data, and the 5-bit access code. For loads, it captures the rotated read word one cycle later, applies byte/halfword selection and sign or zero extension, and returns the result with its destination-register tag to the memory/writeback pipeline register.

## Interface

Parameters:
- ADDR_BITS, default 18: byte-address span of data memory (2^18 bytes).
- TAG_W, default 5: destination-register tag width.

Ports:
- CLOCK_50  in  1: system clock. All state is on the rising edge; the banks are clocked on the falling edge.
- reset  in  1: asynchronous, active-high.
- req_valid  in  1: request present.
- req_ready  out  1: unit can accept a request.
- req_store  in  1: 1 = store, 0 = load.
- req_size  in  2: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_signed  in  1: sign-extend the load result.
- req_addr  in  32: byte address; misaligned addresses are legal.
- req_wdata  in  32: store data, right-justified.
- req_tag  in  TAG_W: destination register.
- mem_address  out  32: to the addresser.
- mem_data_to_store  out  32: left-justified store data.
- mem_access_code  out  5: bit 4 = store; bits 3:0 = byte enables, bit 3 = lowest address.
- mem_prev_r  out  2: address[1:0] of the previous access.
- mem_read_data  in  32: rotated read word; bits 31:24 hold the byte at the lowest address.
- resp_valid  out  1: response available.
- resp_ready  in  1: downstream accepts the response.
- resp_data  out  32: load result; 0 for stores and faults.
- resp_tag  out  TAG_W: echoed req_tag.
- resp_store  out  1: response is a store acknowledge.
- resp_fault  out  1: access was rejected.

## Operation

State machine:
- IDLE: req_ready = 1. On req_valid, latch the request and check for a fault.
  - Fault → RESP.
  - No fault → ACCESS.
- ACCESS: drive the memory port. mem_access_code = {store, enables}.
  - Load → CAPTURE.
  - Store → RESP.
- CAPTURE: hold mem_address, with mem_access_code bit 4 = 0. Latch mem_read_data, extend it, → RESP.
- RESP: resp_valid = 1, all resp_* outputs held stable. On resp_ready → IDLE.

Byte enables and store data formatting:
- Byte: enables 1000, data = wdata[7:0] in bits 31:24.
- Halfword: enables 1100, data = wdata[15:0] in bits 31:16.
- Word: enables 1111, data = wdata unchanged.

Load extension:
- Byte: source is read[31:24]. Sign-extend from bit 31 if req_signed, otherwise zero-extend.
- Halfword: source is read[31:16], extended from bit 31 the same way.
- Word: passed through unchanged.

Fault conditions:
- Fault if req_size == 3.
- Fault if req_addr[31:ADDR_BITS] != 0.
- Fault if req_addr[ADDR_BITS-1:0] + nbytes − 1 overflows ADDR_BITS, i.e. the access would wrap past the top of memory.
- A faulting request performs no memory access. The fault response has resp_data = 0 and resp_fault = 1.

Port behaviour outside ACCESS:
- mem_access_code = 5'b0 whenever the state is not ACCESS, so no spurious writes occur.
- mem_prev_r is a register loaded with mem_address[1:0] at the end of ACCESS and held through CAPTURE.

## Timing

- Latency is measured from the handshake edge E0:
  - Load: resp_valid rises after edge E0+3.
  - Store: resp_valid rises after edge E0+2.
  - Fault: resp_valid rises after edge E0+1.
- Throughput: at most one request per 4 cycles (load) or per 3 cycles (store), plus any resp_ready stall.
- Store write: performed on the falling edge in the middle of the ACCESS cycle.
- Load read: the bank read happens on the ACCESS falling edge. mem_read_data is valid at the rising edge that ends CAPTURE.
- Address stability: mem_address must not change during ACCESS or CAPTURE.
- Reset values: state = IDLE, req_ready = 1 once reset deasserts, and every other output = 0.
- Reset mid-operation: any pending request is dropped and no response is produced. A store is aborted if reset rises before the falling edge of its ACCESS cycle.
- Handshake: resp_valid stays high until resp_ready is seen; resp_data, resp_tag and resp_fault do not change while it is waiting. req_ready = 0 in every state except IDLE.

## Structure

- Shared package `lsu_pkg`:
  - state enum (IDLE, ACCESS, CAPTURE, RESP);
  - size encodings;
  - access-code bit positions (STORE_BIT = 4);
  - byte-enable constants BE_BYTE, BE_HALF, BE_WORD.
- Sub-module `lsu_lane_format`: purely combinational. It covers store-data left-justification, byte-enable generation, load extension, and the fault check. Everything else (FSM and registers) lives in `mem_stage_lsu`.

## Test plan

- Store word 0xDEADBEEF to address 0x00001:
  - During ACCESS, require mem_access_code = 5'b11111 and mem_data_to_store = 0xDEADBEEF.
  - Response after 2 edges with resp_store = 1.
- Then load word from 0x00001 → resp_data = 0xDEADBEEF, mem_prev_r = 1 during CAPTURE.
- Load signed byte from 0x00001 → 0xFFFFFFDE. Load unsigned halfword from 0x00003 → 0x0000BEEF (crosses a word boundary).
- Store byte 0x7F to 0x00000 → mem_access_code = 5'b11000, data = 0x7F000000. A subsequent signed-byte load → 0x0000007F.
- Word store to 0x3FFFE, and any access to 0x00040000 → resp_fault = 1 after 1 edge, mem_access_code stays 0, memory unchanged.
- Hold resp_ready = 0 for 5 cycles during a load: resp_* stable and req_ready = 0. Then assert reset during the ACCESS of a store to 0x10: all outputs = 0 and memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the memory-stage load/store unit.
//   state_t      : LSU control states
//   size_t       : request size encodings
//   STORE_BIT    : position of the store flag in the addresser access code
//   BE_*         : byte-enable patterns; bit 3 is the lowest byte address
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_BAD  = 2'd3
   } size_t;

   localparam int         STORE_BIT = 4;
   localparam logic [3:0] BE_BYTE   = 4'b1000;
   localparam logic [3:0] BE_HALF   = 4'b1100;
   localparam logic [3:0] BE_WORD   = 4'b1111;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: request, response and addresser-port bundle of the LSU.
//   req_*  : pipeline request (valid/ready handshake)
//   mem_*  : byte-lane BRAM addresser request port and rotated read word
//   resp_* : memory/writeback response (valid/ready handshake)
// Modports: master = pipeline/addresser side, slave = the LSU.
interface mem_stage_lsu_if #(
   parameter int TAG_W = 5
) ();

   logic             req_valid;
   logic             req_ready;
   logic             req_store;
   logic [1:0]       req_size;
   logic             req_signed;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [TAG_W-1:0] req_tag;

   logic [31:0]      mem_address;
   logic [31:0]      mem_data_to_store;
   logic [4:0]       mem_access_code;
   logic [1:0]       mem_prev_r;
   logic [31:0]      mem_read_data;

   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             resp_store;
   logic             resp_fault;

   modport master (
      output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_tag,
      output mem_read_data, resp_ready,
      input  req_ready, mem_address, mem_data_to_store, mem_access_code, mem_prev_r,
      input  resp_valid, resp_data, resp_tag, resp_store, resp_fault
   );

   modport slave (
      input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_tag,
      input  mem_read_data, resp_ready,
      output req_ready, mem_address, mem_data_to_store, mem_access_code, mem_prev_r,
      output resp_valid, resp_data, resp_tag, resp_store, resp_fault
   );

endinterface

// File: rtl/lsu_lane_format.sv
// lsu_lane_format: combinational lane formatting for the LSU.
//   chk_size/chk_addr -> fault      : range/size check of an incoming request
//   size/wdata        -> store_data : left-justified store data
//   size              -> byte_en    : byte enables, bit 3 = lowest address
//   size/sign/rdata   -> load_data  : selected and extended load result
module lsu_lane_format
   import lsu_pkg::*;
#(
   parameter int ADDR_BITS = 18
) (
   input  size_t       chk_size,
   input  logic [31:0] chk_addr,
   output logic        fault,
   input  size_t       size,
   input  logic        sign,
   input  logic [31:0] wdata,
   output logic [31:0] store_data,
   output logic [3:0]  byte_en,
   input  logic [31:0] rdata,
   output logic [31:0] load_data
);

   logic [ADDR_BITS:0] span;
   logic [ADDR_BITS:0] last_byte;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; an unassigned path would infer a latch.
   always_comb begin
      span = '0;
      case (chk_size)
         SZ_HALF: span = (ADDR_BITS+1)'(1);
         SZ_WORD: span = (ADDR_BITS+1)'(3);
         default: span = '0;
      endcase
   end

   // One extra carry bit: a set carry means the access wraps past the top.
   assign last_byte = {1'b0, chk_addr[ADDR_BITS-1:0]} + span;
   assign fault     = (chk_size == SZ_BAD) || (|chk_addr[31:ADDR_BITS]) || last_byte[ADDR_BITS];

   always_comb begin
      store_data = '0;
      byte_en    = '0;
      load_data  = '0;
      case (size)
         SZ_BYTE: begin
            store_data = {wdata[7:0], 24'h0};
            byte_en    = BE_BYTE;
            load_data  = {{24{sign & rdata[31]}}, rdata[31:24]};
         end
         SZ_HALF: begin
            store_data = {wdata[15:0], 16'h0};
            byte_en    = BE_HALF;
            load_data  = {{16{sign & rdata[31]}}, rdata[31:16]};
         end
         SZ_WORD: begin
            store_data = wdata;
            byte_en    = BE_WORD;
            load_data  = rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit driving the byte-lane BRAM
// addresser. Accepts one request at a time, performs the access and returns
// a tagged response.
//   CLOCK_50 : system clock, all state on the rising edge
//   reset    : asynchronous, active-high
//   bus      : request / addresser / response bundle (slave side)
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_BITS = 18,
   parameter int TAG_W     = 5
) (
   input  logic           CLOCK_50,
   input  logic           reset,
   mem_stage_lsu_if.slave bus
);

   state_t           state_q, state_d;
   logic             store_q, sign_q, fault_q;
   size_t            size_q;
   logic [31:0]      addr_q, wdata_q, resp_data_q;
   logic [TAG_W-1:0] tag_q;
   logic [1:0]       prev_r_q;

   logic             req_fault;
   logic [31:0]      store_data, load_data;
   logic [3:0]       byte_en;
   logic [4:0]       access_code;
   logic             resp_valid;

   // Fault check looks at the live request; formatting works on the latched one.
   lsu_lane_format #(.ADDR_BITS(ADDR_BITS)) u_fmt (
      .chk_size   (size_t'(bus.req_size)),
      .chk_addr   (bus.req_addr),
      .fault      (req_fault),
      .size       (size_q),
      .sign       (sign_q),
      .wdata      (wdata_q),
      .store_data (store_data),
      .byte_en    (byte_en),
      .rdata      (bus.mem_read_data),
      .load_data  (load_data)
   );

   always_comb begin
      state_d     = state_q;
      access_code = '0;
      resp_valid  = 1'b0;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = req_fault ? RESP : ACCESS;
         ACCESS: begin
            access_code = {store_q, byte_en};
            state_d     = store_q ? RESP : CAPTURE;
         end
         CAPTURE: state_d = RESP;
         RESP: begin
            resp_valid = 1'b1;
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the async reset sits in the sensitivity list.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         store_q     <= 1'b0;
         sign_q      <= 1'b0;
         fault_q     <= 1'b0;
         size_q      <= SZ_BYTE;
         addr_q      <= '0;
         wdata_q     <= '0;
         tag_q       <= '0;
         resp_data_q <= '0;
         prev_r_q    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (bus.req_valid) begin
               store_q     <= bus.req_store;
               sign_q      <= bus.req_signed;
               size_q      <= size_t'(bus.req_size);
               addr_q      <= bus.req_addr;
               wdata_q     <= bus.req_wdata;
               tag_q       <= bus.req_tag;
               fault_q     <= req_fault;
               resp_data_q <= '0;
            end
            ACCESS:  prev_r_q    <= addr_q[1:0];
            CAPTURE: resp_data_q <= load_data;
            default: ;
         endcase
      end
   end

   assign bus.req_ready         = (state_q == IDLE) && !reset;
   assign bus.mem_address       = addr_q;
   assign bus.mem_data_to_store = store_data;
   assign bus.mem_access_code   = access_code;
   assign bus.mem_prev_r        = prev_r_q;
   assign bus.resp_valid        = resp_valid;
   assign bus.resp_data         = resp_data_q;
   assign bus.resp_tag          = tag_q;
   assign bus.resp_store        = store_q;
   assign bus.resp_fault        = fault_q;

endmodule
